register_file_wb: RTL



---
 rtl/datapath_pkg.sv | 25 ++
 rtl/regfile_wb_stage.sv | 44 ++++
 rtl/register_file_wb.sv | 70 +++++++
 3 files changed

// File: rtl/datapath_pkg.sv
// datapath_pkg: shared datapath widths and function-unit select encodings.
// Contents:
//   DATA_WIDTH, ADDR_WIDTH  default operand width and register address width
//   fs_t                    4-bit function-select codes used by the function unit
package datapath_pkg;
   localparam int DATA_WIDTH = 16;
   localparam int ADDR_WIDTH = 3;
   typedef enum logic [3:0] {
      FS_TRANSFER_A = 4'b0000,
      FS_INC_A      = 4'b0001,
      FS_ADD        = 4'b0010,
      FS_ADD_INC    = 4'b0011,
      FS_ADD_NOT_B  = 4'b0100,
      FS_SUB        = 4'b0101,
      FS_DEC_A      = 4'b0110,
      FS_TRANSFER_A2 = 4'b0111,
      FS_AND        = 4'b1000,
      FS_OR         = 4'b1001,
      FS_XOR        = 4'b1010,
      FS_NOT_A      = 4'b1011,
      FS_TRANSFER_B = 4'b1100,
      FS_SHR_B      = 4'b1101,
      FS_SHL_B      = 4'b1110
   } fs_t;
endpackage

// File: rtl/regfile_wb_stage.sv
// regfile_wb_stage: one-entry write-back stage with read-forwarding hit detection.
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   rw, da, d_data        write request captured on each rising edge
//   aa, ba                read addresses compared against the held entry
//   wb_valid, wb_addr,    held (uncommitted) write entry
//   wb_data
//   hit_a, hit_b          held entry matches aa / ba
module regfile_wb_stage
   import datapath_pkg::*;
#(
   parameter int DW = DATA_WIDTH,
   parameter int AW = ADDR_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          rw,
   input  logic [AW-1:0] da,
   input  logic [DW-1:0] d_data,
   input  logic [AW-1:0] aa,
   input  logic [AW-1:0] ba,
   output logic          wb_valid,
   output logic [AW-1:0] wb_addr,
   output logic [DW-1:0] wb_data,
   output logic          hit_a,
   output logic          hit_b
);
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wb_valid <= 1'b0;
         wb_addr  <= '0;
         wb_data  <= '0;
      end else begin
         wb_valid <= rw;
         if (rw) begin
            wb_addr <= da;
            wb_data <= d_data;
         end
      end
   end

   assign hit_a = wb_valid && (wb_addr == aa);
   assign hit_b = wb_valid && (wb_addr == ba);
endmodule

// File: rtl/register_file_wb.sv
// register_file_wb: 8x16 register file with a one-entry write-back stage,
// forwarding reads and an immediate mux on operand B.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   rw, da, d_data     write request, destination, write data (bus D)
//   aa, ba             A / B read addresses
//   mb, constant_in    B operand select (1 = constant_in) and immediate
//   a_data, b_data     operands to the function unit
//   dbg_addr, dbg_data architectural (non-forwarded) array read
//   wb_pending         write-back stage holds an uncommitted write
module register_file_wb
   import datapath_pkg::*;
#(
   parameter int DATA_WIDTH = datapath_pkg::DATA_WIDTH,
   parameter int ADDR_WIDTH = datapath_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rw,
   input  logic [ADDR_WIDTH-1:0] da,
   input  logic [DATA_WIDTH-1:0] d_data,
   input  logic [ADDR_WIDTH-1:0] aa,
   input  logic [ADDR_WIDTH-1:0] ba,
   input  logic                  mb,
   input  logic [DATA_WIDTH-1:0] constant_in,
   output logic [DATA_WIDTH-1:0] a_data,
   output logic [DATA_WIDTH-1:0] b_data,
   input  logic [ADDR_WIDTH-1:0] dbg_addr,
   output logic [DATA_WIDTH-1:0] dbg_data,
   output logic                  wb_pending
);
   localparam int NUM_REGS = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic                  wb_valid;
   logic [ADDR_WIDTH-1:0] wb_addr;
   logic [DATA_WIDTH-1:0] wb_data;
   logic                  hit_a;
   logic                  hit_b;

   regfile_wb_stage #(.DW(DATA_WIDTH), .AW(ADDR_WIDTH)) u_wb (
      .clk      (clk),
      .rst      (rst),
      .rw       (rw),
      .da       (da),
      .d_data   (d_data),
      .aa       (aa),
      .ba       (ba),
      .wb_valid (wb_valid),
      .wb_addr  (wb_addr),
      .wb_data  (wb_data),
      .hit_a    (hit_a),
      .hit_b    (hit_b)
   );

   // The held entry commits on the same edge a new one is captured; reset
   // clears the array and drops the held entry without committing it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (wb_valid) begin
         regs[wb_addr] <= wb_data;
      end
   end

   assign a_data     = hit_a ? wb_data : regs[aa];
   assign b_data     = mb ? constant_in : (hit_b ? wb_data : regs[ba]);
   assign dbg_data   = regs[dbg_addr];
   assign wb_pending = wb_valid;
endmodule
